// File: rtl/bit_serial_subtractor.sv
// LSB-first bit-serial subtractor: D = A - B over WIDTH-bit frames, borrow chained through a flop.
// Latency: difference bit 1 cycle after acceptance; done/result/borrow_out 1 cycle after last bit.
// Backpressure: none; the source paces bits with in_valid and gaps of any length are tolerated.
module bit_serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             a,
  input  logic             b,
  output logic             d_valid,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow_out,
  output logic             protocol_err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_borrow;
  logic [WIDTH-1:0] r_shift;
  logic             r_d_valid;
  logic             r_d;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_borrow_out;
  logic             r_protocol_err;

  logic             w_run;
  logic             w_accept;
  logic             w_bad;
  logic             w_bin;
  logic             w_diff;
  logic             w_bout;
  logic             w_last;
  logic [WIDTH-1:0] w_shift_nxt;

  assign w_run    = (r_state == RUN);
  // A bit is taken when it starts a frame or continues one already running.
  assign w_accept = in_valid & (in_first | w_run);
  // Illegal framing: a continuation bit with no frame open, or a restart mid-frame.
  assign w_bad    = in_valid & (in_first ? w_run : ~w_run);
  // Bit 0 never sees a borrow in, even when it restarts an abandoned frame.
  assign w_bin    = in_first ? 1'b0 : r_borrow;
  assign w_diff   = a ^ b ^ w_bin;
  assign w_bout   = (~a & b) | (~(a ^ b) & w_bin);
  // WIDTH >= 2, so a first bit can never also be the last one.
  assign w_last   = w_accept & ~in_first & (r_cnt == CNT_W'(WIDTH - 1));
  assign w_shift_nxt = {w_diff, r_shift[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: open a frame on an accepted first bit, close it after the last bit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RUN;
      RUN:     if (w_last)   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: bit counter, borrow chain, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_borrow       <= 1'b0;
      r_shift        <= '0;
      r_d_valid      <= 1'b0;
      r_d            <= 1'b0;
      r_done         <= 1'b0;
      r_result       <= '0;
      r_borrow_out   <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      r_d_valid      <= w_accept;
      r_done         <= w_last;
      r_protocol_err <= w_bad;
      if (w_accept) begin
        r_d      <= w_diff;
        r_borrow <= w_bout;
        r_shift  <= w_shift_nxt;
        if (in_first)    r_cnt <= CNT_W'(1);
        else if (w_last) r_cnt <= '0;
        else             r_cnt <= r_cnt + 1'b1;
      end
      if (w_last) begin
        r_result     <= w_shift_nxt;
        r_borrow_out <= w_bout;
      end
    end
  end

  assign d_valid      = r_d_valid;
  assign d            = r_d;
  assign busy         = w_run;
  assign done         = r_done;
  assign result       = r_result;
  assign borrow_out   = r_borrow_out;
  assign protocol_err = r_protocol_err;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Self-checking bench for bit_serial_subtractor: directed frames plus random frames with random gaps.
// Reference model accumulates operand values and derives expectations with plain integer subtraction.
// Inputs change on the falling edge; outputs are checked 1 time unit after each rising edge.
module tb_bit_serial_subtractor;

  localparam int W = 8;
  localparam int unsigned MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_first = 1'b0;
  logic         a = 1'b0;
  logic         b = 1'b0;
  logic         d_valid;
  logic         d;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         borrow_out;
  logic         protocol_err;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  bit          m_run = 1'b0;
  int          m_i = 0;
  int unsigned m_a = 0;
  int unsigned m_b = 0;
  logic        e_d = 1'b0;
  logic [W-1:0] e_res = '0;
  logic        e_bo = 1'b0;
  int          done_cnt = 0;

  bit_serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
    .a(a), .b(b), .d_valid(d_valid), .d(d), .busy(busy), .done(done),
    .result(result), .borrow_out(borrow_out), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, then compare every output.
  task automatic step(input logic r, input logic v, input logic f, input logic ia, input logic ib);
    logic acc;
    logic e_dv;
    logic e_done;
    logic e_err;
    @(negedge clk);
    rst = r; in_valid = v; in_first = f; a = ia; b = ib;
    e_dv = 1'b0; e_done = 1'b0; e_err = 1'b0;
    if (r) begin
      m_run = 1'b0; m_i = 0; m_a = 0; m_b = 0;
      e_d = 1'b0; e_res = '0; e_bo = 1'b0;
    end else begin
      acc   = v && (f || m_run);
      e_err = v && (f ? m_run : !m_run);
      if (acc) begin
        if (f) begin m_a = 0; m_b = 0; m_i = 0; end
        m_a = m_a | (int'(ia) << m_i);
        m_b = m_b | (int'(ib) << m_i);
        e_d  = logic'(((m_a - m_b) >> m_i) & 1);
        e_dv = 1'b1;
        m_i++;
        m_run = 1'b1;
        if (m_i == W) begin
          m_run  = 1'b0;
          e_done = 1'b1;
          e_res  = W'((m_a - m_b) & MASK);
          e_bo   = (m_a < m_b);
        end
      end
    end
    @(posedge clk);
    #1;
    if (done) done_cnt++;
    chk("d_valid", 32'(d_valid), 32'(e_dv));
    chk("d", 32'(d), 32'(e_d));
    chk("busy", 32'(busy), 32'(m_run));
    chk("done", 32'(done), 32'(e_done));
    chk("protocol_err", 32'(protocol_err), 32'(e_err));
    chk("result", 32'(result), 32'(e_res));
    chk("borrow_out", 32'(borrow_out), 32'(e_bo));
  endtask

  // Send bits [0, nbits) of a frame, with up to maxgap idle cycles before each non-first bit.
  task automatic send_frame(input logic [W-1:0] fa, input logic [W-1:0] fb,
                            input int maxgap, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (i > 0 && maxgap > 0) begin
        int g;
        g = $urandom_range(maxgap, 0);
        for (int k = 0; k < g; k++) step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
      end
      step(1'b0, 1'b1, (i == 0), fa[i], fb[i]);
    end
  endtask

  initial begin
    int dc0;
    // Reset state.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Basic subtraction, no borrow, then a borrowing one.
    send_frame(8'h05, 8'h03, 0, W);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    dc0 = done_cnt;
    send_frame(8'h03, 8'h05, 0, W);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("done_once", 32'(done_cnt - dc0), 32'd1);

    // Equal operands with random gaps.
    send_frame(8'hA5, 8'hA5, 3, W);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Restart mid-frame at bit 4, then a full frame.
    dc0 = done_cnt;
    send_frame(8'hFF, 8'h01, 0, 4);
    send_frame(8'h10, 8'h01, 0, W);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("restart_done_count", 32'(done_cnt - dc0), 32'd1);

    // Continuation bits while idle are dropped and flagged.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset after 5 bits, then a borrowing frame.
    send_frame(8'h3C, 8'h5A, 1, 5);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h80, 8'h81, 0, W);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back frames with no idle cycle between them.
    send_frame(8'h05, 8'h03, 0, W);
    send_frame(8'h03, 8'h05, 0, W);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random frames, gaps, back-to-back and occasional stray bits.
    for (int n = 0; n < 40; n++) begin
      send_frame(W'($urandom), W'($urandom), $urandom_range(2, 0), W);
      if ($urandom_range(3, 0) == 0) step(1'b0, 1'b1, 1'b0, 1'($urandom), 1'($urandom));
      if ($urandom_range(3, 0) == 0) send_frame(W'($urandom), W'($urandom), 1, $urandom_range(W - 1, 1));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_serial_subtractor.md
Name: bit_serial_subtractor

Overview:
LSB-first bit-serial subtractor computing D = A − B over frames of WIDTH bits, using a registered borrow flop between bits. It is the inverse-operation companion to the team's combinational full-adder cell. It streams each difference bit out one cycle after input and assembles the parallel result. It also flags a borrow (A < B) at frame end. It sits between serial operand sources and downstream parallel consumers.

Parameters:
WIDTH, 8, bits per operand frame (≥2)
CNT_W, $clog2(WIDTH+1), width of internal bit counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  a/b bit present this cycle
in_first  input  1  qualifies bit 0 (LSB) of a frame; only meaningful with in_valid
a  input  1  minuend bit
b  input  1  subtrahend bit
d_valid  output  1  d carries a difference bit
d  output  1  difference bit
busy  output  1  frame in progress (bit 0 accepted, last bit not yet accepted)
done  output  1  one-cycle pulse: frame complete, result/borrow_out valid
result  output  WIDTH  assembled difference, held until next done
borrow_out  output  1  final borrow of frame (1 ⇔ A < B unsigned), held with result
protocol_err  output  1  one-cycle pulse on illegal framing

Behaviour:
- Reset (rst=1 at edge): d_valid=0, d=0, busy=0, done=0, result=0, borrow_out=0, protocol_err=0, borrow flop=0, counter=0, shift reg=0. Reset overrides all inputs; a frame in progress is discarded, with no done.
- States: IDLE (busy=0), RUN (busy=1).
- Accepted bit: in_valid=1 and (in_first=1, or state RUN).
- Per accepted bit, with bin = 0 if in_first, else the borrow flop:
  - diff = a ^ b ^ bin
  - bout = (~a & b) | (~(a ^ b) & bin)
- d/d_valid are registered: the cycle after acceptance, d_valid=1 and d=diff. Otherwise d_valid=0 and d holds its last value.
- diff shifts into the result shift register from the MSB end, so after WIDTH bits bit0 is in result[0]. The borrow flop is loaded with bout.
- IDLE + in_valid + in_first: accept bit 0, counter=1, go to RUN.
- IDLE + in_valid + !in_first: drop the bit, pulse protocol_err next cycle, no d_valid.
- RUN + in_valid + !in_first: accept, counter++.
- RUN + in_valid + in_first (restart mid-frame): pulse protocol_err. Abandon the current frame with no done. Treat this bit as bit 0 of a new frame, with the borrow flop using bin=0 and counter=1.
- RUN + in_valid=0: hold all state. Gaps of any length are legal.
- Frame end: when the accepted bit is bit WIDTH−1, go to IDLE next cycle.
  - In that same next cycle: done=1, result = the final shifted value including that bit, borrow_out = bout of that bit, d_valid=1 for that bit.
- WIDTH=... edge: if in_first arrives together with completion of the previous frame (back-to-back frames), it is handled normally in the next cycle with no bubble. A next-frame in_first in the cycle directly after the last bit is accepted.
- result/borrow_out change only on done, or on reset.
- Latency: 1 cycle from bit acceptance to d. 1 cycle from last bit to done.

Test Plan:
- WIDTH=8, A=0x05, B=0x03, no gaps → d stream 0,1,0,0,0,0,0,0; done one cycle after bit 7; result=0x02, borrow_out=0.
- A=0x03, B=0x05 → result=0xFE, borrow_out=1, done pulses exactly once.
- A=B=0xA5, with a random 0–3 cycle in_valid gap between every bit → result=0x00, borrow_out=0; d_valid count=8; busy high from bit 0 to bit 7.
- Frame A=0xFF/B=0x01 restarted with in_first at bit 4, then full frame A=0x10, B=0x01 → one protocol_err pulse, no done for the aborted frame, then result=0x0F, borrow_out=0.
- in_valid=1, in_first=0 while IDLE → protocol_err pulse, d_valid stays 0, busy stays 0.
- rst asserted after 5 bits of a frame → all outputs 0 next cycle, no done. A following frame A=0x80, B=0x81 → result=0xFF, borrow_out=1.
- Back-to-back frames (0x05−0x03, then 0x03−0x05) with no idle cycle → two done pulses 8 cycles apart, results 0x02/0 then 0xFE/1.
